// File: rtl/reaction_ctrl.sv
// Trial sequencer for the reaction timer: random foreperiod, GO light, response
// capture and best-time tracking on top of the external time_count block.
module reaction_ctrl #(
  parameter int          MIN_WAIT_MS = 1000,
  parameter int          RAND_BITS   = 11,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_btn,
  input  logic       stop_btn,
  input  logic       tick_1ms,
  input  logic [3:0] d0,
  input  logic [3:0] d1,
  input  logic [3:0] d2,
  input  logic [3:0] d3,
  input  logic       time_late,
  output logic       time_clr,
  output logic       time_en,
  output logic       led_go,
  output logic [2:0] state,
  output logic [3:0] b0,
  output logic [3:0] b1,
  output logic [3:0] b2,
  output logic [3:0] b3,
  output logic       new_best
);

  localparam int WAIT_W = $clog2(MIN_WAIT_MS + (1 << RAND_BITS));

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_GO    = 3'd2,
    S_DONE  = 3'd3,
    S_EARLY = 3'd4,
    S_LATE  = 3'd5
  } state_e;

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [15:0]       lfsr_q, lfsr_d;
  logic [15:0]       best_q, best_d;
  logic              start_q, stop_q;
  logic              first_done_q, first_done_d;
  logic              new_best_q, new_best_d;
  logic              start_rise, stop_rise;
  logic [WAIT_W-1:0] wait_load;
  logic [15:0]       cur_time;

  assign start_rise = start_btn & ~start_q;
  assign stop_rise  = stop_btn & ~stop_q;
  assign wait_load  = WAIT_W'(MIN_WAIT_MS) + WAIT_W'(lfsr_q[RAND_BITS-1:0]);
  // Packed BCD compares in numeric order as long as every digit is valid.
  assign cur_time   = {d3, d2, d1, d0};

  always_comb begin
    state_d      = state_q;
    wait_d       = wait_q;
    lfsr_d       = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    best_d       = best_q;
    new_best_d   = 1'b0;
    first_done_d = 1'b0;

    if (first_done_q && (cur_time < best_q)) begin
      best_d     = cur_time;
      new_best_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (start_rise) begin
          state_d = S_WAIT;
          wait_d  = wait_load;
        end
      end
      S_WAIT: begin
        // An early press wins over expiry on the same edge.
        if (stop_rise) begin
          state_d = S_EARLY;
        end else if (tick_1ms) begin
          wait_d = wait_q - WAIT_W'(1);
          if (wait_q == WAIT_W'(1)) state_d = S_GO;
        end
      end
      S_GO: begin
        if (time_late) begin
          state_d = S_LATE;
        end else if (stop_rise) begin
          state_d      = S_DONE;
          first_done_d = 1'b1;
        end
      end
      S_DONE, S_EARLY, S_LATE: begin
        if (start_rise) begin
          state_d = S_WAIT;
          wait_d  = wait_load;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      wait_q       <= '0;
      lfsr_q       <= LFSR_SEED;
      best_q       <= 16'h9999;
      start_q      <= 1'b0;
      stop_q       <= 1'b0;
      first_done_q <= 1'b0;
      new_best_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_q       <= wait_d;
      lfsr_q       <= lfsr_d;
      best_q       <= best_d;
      start_q      <= start_btn;
      stop_q       <= stop_btn;
      first_done_q <= first_done_d;
      new_best_q   <= new_best_d;
    end
  end

  assign state    = state_q;
  assign time_clr = (state_q == S_IDLE) || (state_q == S_WAIT);
  assign time_en  = (state_q == S_GO);
  assign led_go   = (state_q == S_GO);
  assign new_best = new_best_q;
  assign b3       = best_q[15:12];
  assign b2       = best_q[11:8];
  assign b1       = best_q[7:4];
  assign b0       = best_q[3:0];

endmodule
